multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM for the multicycle MIPS datapath: sequences FETCH/DECODE/EXEC/MEM/WB around the shared
//  memory port, register file and ALU. Consumes op/func fields split out by the instruction decoder.
//  Drives all datapath enables and muxes. Waits on a req/ready memory handshake guarded by a timeout.
// PARAMETERS
//  TIMEOUT   16  max cycles mem_req may stay high unanswered before mem_err (>=2)
//  CNT_W     32  width of perf counters (CTRL_PERF_EN only)
// PORTS
//  clk          in   1  sole clock, rising edge
//  reset        in   1  synchronous, active-high
//  op           in   6  instruction[31:26] from decoder (valid from DECODE onward)
//  func         in   6  instruction[5:0] from decoder
//  zero         in   1  ALU zero flag (beq)
//  mem_ready    in   1  memory completes request this cycle
//  mem_req      out  1  memory request, held until mem_ready
//  mem_we       out  1  1=write (sw), 0=read; valid while mem_req
//  iord         out  1  0=address from PC, 1=address from ALUOut
//  ir_write     out  1  latch instruction register
//  pc_write     out  1  PC <= pc_src selection
//  pc_src       out  2  0=PC+4, 1=branch target, 2=jump target
//  reg_write    out  1  register file write strobe
//  reg_dst      out  1  0=rt, 1=rd
//  mem_to_reg   out  1  0=ALUOut, 1=MDR
//  alu_src_a    out  1  0=PC, 1=rs
//  alu_src_b    out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  alu_op       out  2  0=add, 1=sub, 2=per func, 3=reserved
//  illegal_op   out  1  1-cycle pulse: unsupported opcode
//  mem_err      out  1  1-cycle pulse: handshake timeout
//  busy         out  1  0 only in FETCH before mem_req issued (idle point)
// BEHAVIOUR
//  - Moore FSM; all outputs decoded from registered state (+ timeout pulse flags). One state transition/clk.
//  - States: FETCH, DECODE, EXEC, MEM, WB. Enum is 3 bits; unused codes -> FETCH next clock.
//  - FETCH: mem_req=1,iord=0,mem_we=0; on mem_ready: ir_write=1,pc_write=1,pc_src=0,alu PC+4 -> DECODE.
//  - DECODE: alu_src_a=0,alu_src_b=3,alu_op=0 (branch target precompute). Next by op:
//    000000 R / 100011 lw / 101011 sw / 001000 addi / 000100 beq / 000010 j -> EXEC;
//    any other op: illegal_op=1 for exactly one cycle, -> FETCH.
//  - EXEC: R: src_a=1,src_b=0,alu_op=2 -> WB. lw/sw/addi: src_a=1,src_b=2,alu_op=0 -> MEM (lw,sw) or WB (addi).
//    beq: src_a=1,src_b=0,alu_op=1,pc_src=1,pc_write=zero -> FETCH. j: pc_src=2,pc_write=1 -> FETCH.
//  - MEM: mem_req=1,iord=1,mem_we=(op==sw); on mem_ready: sw -> FETCH, lw -> WB (MDR latched by datapath).
//  - WB: reg_write=1; R: reg_dst=1,mem_to_reg=0; addi: reg_dst=0,mem_to_reg=0; lw: reg_dst=0,mem_to_reg=1 -> FETCH.
//  - Enables (ir_write,pc_write,reg_write) never high outside the listed cycles; default 0.
//  - Timeout: wait counter clears on entering FETCH/MEM, increments each cycle mem_req=1 && !mem_ready.
//    At count==TIMEOUT-1 with no ready: mem_err pulse next cycle, mem_req drops, state -> FETCH
//    (PC unchanged, no IR write). mem_ready on the final wait cycle wins over timeout.
//  - op latched at DECODE into op_q; later states use op_q (IR may change under datapath control).
//  - Reset (any cycle, incl. mid-MEM): state=FETCH, counter=0, op_q=0; all outputs 0 during reset cycle
//    except FETCH decode applies from first cycle after reset release.
// CONFIGURATION
//  CTRL_PERF_EN defined: adds outputs cyc_cnt[CNT_W] (+1 every clk out of reset) and ins_cnt[CNT_W]
//    (+1 on each transition into FETCH from WB/EXEC/MEM completion; not on illegal/timeout); both wrap, reset 0.
//  Undefined: ports and counters absent; core FSM behaviour bit-identical.
// STRUCTURE
//  Package mips_ctrl_pkg: state enum, opcode localparams (OP_RTYPE,OP_LW,OP_SW,OP_ADDI,OP_BEQ,OP_J),
//    alu_op / pc_src / alu_src_b encodings shared with datapath and ALU control.
//  Sub-module ctrl_mem_timer: wait counter + timeout pulse; FSM remains in multicycle_ctrl.
// TESTING
//  1 reset, mem_ready=1, op=000000 -> FETCH,DECODE,EXEC(alu_op=2),WB(reg_write=1,reg_dst=1), 4 clks/instr.
//  2 lw with mem_ready delayed 3 clks in MEM -> mem_req held 4 clks, then WB mem_to_reg=1; 5 states total.
//  3 beq zero=1 -> pc_write=1,pc_src=1 in EXEC; zero=0 -> pc_write=0; both return to FETCH.
//  4 op=111111 -> illegal_op pulses 1 cycle in DECODE, no reg_write/mem_req, next state FETCH.
//  5 mem_ready held 0 in FETCH, TIMEOUT=16 -> mem_err at cycle 16, ir_write never asserted, FETCH re-issued.
//  6 reset asserted mid-MEM of sw -> mem_req=0 next clk, FETCH after release; CTRL_PERF_EN: counters read 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control path
// Holds state codes, opcode values and the alu_op / pc_src / alu_src_b
// encodings used by the control FSM, datapath and ALU control.
package mips_ctrl_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_FUNC = 2'd2;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// rtl/ctrl_mem_timer.sv - memory handshake wait counter with timeout pulse
// Ports: clk, reset (sync, active-high); req/ready = memory handshake;
//   timeout = last permitted wait cycle expired this cycle (combinational);
//   err = registered timeout, high for the one cycle after expiry;
//   idle = counter at zero (no cycles waited yet).
module ctrl_mem_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic ready,
  output logic timeout,
  output logic err,
  output logic idle
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // ready on the final wait cycle wins: timeout needs !ready
  assign timeout = req && !ready && (cnt == LAST);
  assign idle    = (cnt == '0);

  // Counter only runs while a request is outstanding; any completion,
  // expiry or idle cycle clears it, so each FETCH/MEM visit starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= timeout;
      if (req && !ready && !timeout) cnt <= cnt + 1'b1;
      else                           cnt <= '0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for the multicycle MIPS datapath
// Optional feature macro: CTRL_PERF_EN (adds cyc_cnt / ins_cnt counters).
// Ports: clk, reset (sync, active-high); op/func from decoder; zero from ALU;
//   mem_ready/mem_req/mem_we/iord = memory handshake and address select;
//   ir_write/pc_write/pc_src/reg_write/reg_dst/mem_to_reg/alu_src_a/
//   alu_src_b/alu_op = datapath controls; illegal_op, mem_err = 1-cycle
//   pulses; busy = low only at the FETCH idle point.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic             mem_err,
  output logic             busy
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ins_cnt
`endif
);

  logic [2:0] state, state_nxt;
  logic [5:0] op_q;
  logic       req_int, done;
  logic       wait_timeout, wait_err, wait_idle;

  // func selects the ALU function inside ALU control, not here
  logic unused_func;
  assign unused_func = ^func;

  // Request is suppressed for the single cycle carrying the mem_err pulse.
  assign req_int = ((state == ST_FETCH) || (state == ST_MEM)) && !wait_err;
  assign done    = req_int && mem_ready;

  ctrl_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .req     (req_int),
    .ready   (mem_ready),
    .timeout (wait_timeout),
    .err     (wait_err),
    .idle    (wait_idle)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (wait_timeout) state_nxt = ST_FETCH;
                 else if (done)    state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = op_supported(op) ? ST_EXEC : ST_FETCH;
      ST_EXEC: begin
        case (op_q)
          OP_RTYPE, OP_ADDI: state_nxt = ST_WB;
          OP_LW, OP_SW:      state_nxt = ST_MEM;
          default:           state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM:    if (wait_timeout) state_nxt = ST_FETCH;
                 else if (done)    state_nxt = (op_q == OP_LW) ? ST_WB : ST_FETCH;
      ST_WB:     state_nxt = ST_FETCH;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  // op_q holds the opcode seen in DECODE; the IR may be reloaded later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) op_q <= op;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    illegal_op = 1'b0;
    mem_err    = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      mem_err = wait_err;
      // idle point: FETCH with no wait cycles accumulated yet
      busy    = !((state == ST_FETCH) && wait_idle);
      case (state)
        ST_FETCH: begin
          mem_req   = req_int;
          alu_src_b = SRCB_FOUR;
          ir_write  = done;
          pc_write  = done;
        end
        ST_DECODE: begin
          alu_src_b  = SRCB_IMM_SH;
          illegal_op = !op_supported(op);
        end
        ST_EXEC: begin
          case (op_q)
            OP_RTYPE: begin
              alu_src_a = 1'b1;
              alu_op    = ALU_FUNC;
            end
            OP_LW, OP_SW, OP_ADDI: begin
              alu_src_a = 1'b1;
              alu_src_b = SRCB_IMM;
            end
            OP_BEQ: begin
              alu_src_a = 1'b1;
              alu_op    = ALU_SUB;
              pc_src    = PC_BRANCH;
              pc_write  = zero;
            end
            OP_J: begin
              pc_src   = PC_JUMP;
              pc_write = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_req = req_int;
          iord    = 1'b1;
          mem_we  = req_int && (op_q == OP_SW);
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (op_q == OP_RTYPE);
          mem_to_reg = (op_q == OP_LW);
        end
        default: ;
      endcase
    end
  end

`ifdef CTRL_PERF_EN
  logic retire;
  // completed instructions only; illegal ops and timeouts are not counted
  assign retire = (state == ST_WB) ||
                  ((state == ST_EXEC) && ((op_q == OP_BEQ) || (op_q == OP_J))) ||
                  ((state == ST_MEM) && done && (op_q == OP_SW));

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (retire) ins_cnt <= ins_cnt + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] func = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       illegal_op, mem_err, busy;
`ifdef CTRL_PERF_EN
  logic [31:0] cyc_cnt, ins_cnt;
`endif

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op), .mem_err(mem_err), .busy(busy)
`ifdef CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
`endif
  );

  logic [17:0] outs;
  assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                 illegal_op, mem_err, busy};

  function automatic logic [17:0] ov(
    input logic req, we, io, irw, pcw, input logic [1:0] ps,
    input logic rw, rd, m2r, sa, input logic [1:0] sb, ao,
    input logic ill, err, bsy);
    return {req, we, io, irw, pcw, ps, rw, rd, m2r, sa, sb, ao, ill, err, bsy};
  endfunction

  logic [17:0] f_rdy, f_w0, f_wn, f_rn, e_err, dec, dill, exr, exi, exb1, exb0;
  logic [17:0] exj, mlw, msw, wbr, wba, wbl, zro;

  // Inputs are applied at the falling edge, outputs checked 1 time unit later.
  task automatic step(input string tag, input logic rst, input logic rdy,
                      input logic [5:0] opv, input logic z, input logic [17:0] exp);
    @(negedge clk);
    reset = rst; mem_ready = rdy; op = opv; zero = z;
    #1;
    n_assert++;
    assert (outs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", tag, outs, exp);
      end
  endtask

`ifdef CTRL_PERF_EN
  task automatic chk_cnt(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          req we io irw pcw ps rw rd m2r sa sb ao ill err busy
    f_rdy = ov(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    f_w0  = ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    f_wn  = ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    f_rn  = ov(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    e_err = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    dec   = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1);
    dill  = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0, 1);
    exr   = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1);
    exi   = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1);
    exb1  = ov(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    exb0  = ov(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1);
    exj   = ov(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    mlw   = ov(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    msw   = ov(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    wbr   = ov(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    wba   = ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    wbl   = ov(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    zro   = '0;

    // reset: every output low, even with mem_ready high
    step("reset0", 1, 1, 6'h00, 0, zro);
    step("reset1", 1, 1, 6'h00, 0, zro);

    // R-type: 4 clocks per instruction
    step("r_fetch",  0, 1, 6'h00, 0, f_rdy);
`ifdef CTRL_PERF_EN
    chk_cnt("cyc_start", cyc_cnt, 32'd0);
`endif
    step("r_decode", 0, 1, 6'h00, 0, dec);
    step("r_exec",   0, 1, 6'h3f, 0, exr);
    step("r_wb",     0, 1, 6'h3f, 0, wbr);
    step("r_next",   0, 1, 6'h00, 0, f_rdy);
`ifdef CTRL_PERF_EN
    chk_cnt("cyc_r", cyc_cnt, 32'd4);
    chk_cnt("ins_r", ins_cnt, 32'd1);
`endif

    // addi
    step("addi_decode", 0, 0, 6'h08, 0, dec);
    step("addi_exec",   0, 0, 6'h00, 0, exi);
    step("addi_wb",     0, 0, 6'h00, 0, wba);

    // lw with ready delayed three clocks; op input scrambled after DECODE
    step("lw_fetch",  0, 1, 6'h00, 0, f_rdy);
    step("lw_decode", 0, 0, 6'h23, 0, dec);
    step("lw_exec",   0, 0, 6'h3f, 0, exi);
    step("lw_mem0",   0, 0, 6'h3f, 0, mlw);
    step("lw_mem1",   0, 0, 6'h3f, 0, mlw);
    step("lw_mem2",   0, 0, 6'h3f, 0, mlw);
    step("lw_mem3",   0, 1, 6'h3f, 0, mlw);
    step("lw_wb",     0, 0, 6'h2b, 0, wbl);

    // sw completes immediately
    step("sw_fetch",  0, 1, 6'h00, 0, f_rdy);
    step("sw_decode", 0, 0, 6'h2b, 0, dec);
    step("sw_exec",   0, 0, 6'h00, 0, exi);
    step("sw_mem",    0, 1, 6'h00, 0, msw);

    // beq taken, beq not taken, jump
    step("beq1_fetch",  0, 1, 6'h00, 0, f_rdy);
    step("beq1_decode", 0, 0, 6'h04, 0, dec);
    step("beq1_exec",   0, 0, 6'h00, 1, exb1);
    step("beq0_fetch",  0, 1, 6'h00, 0, f_rdy);
    step("beq0_decode", 0, 0, 6'h04, 0, dec);
    step("beq0_exec",   0, 0, 6'h00, 0, exb0);
    step("j_fetch",     0, 1, 6'h00, 0, f_rdy);
    step("j_decode",    0, 0, 6'h02, 0, dec);
    step("j_exec",      0, 0, 6'h00, 0, exj);

    // illegal opcode: one-cycle pulse then straight back to FETCH
    step("ill_fetch",  0, 1, 6'h00, 0, f_rdy);
    step("ill_decode", 0, 0, 6'h3f, 0, dill);
    step("ill_after",  0, 0, 6'h3f, 0, f_w0);

    // ready on the final permitted wait cycle still completes the fetch
    for (int i = 1; i <= 14; i++) step("late_wait", 0, 0, 6'h00, 0, f_wn);
    step("late_ready",  0, 1, 6'h00, 0, f_rn);
    step("late_decode", 0, 0, 6'h08, 0, dec);
    step("late_exec",   0, 0, 6'h00, 0, exi);
    step("late_wb",     0, 0, 6'h00, 0, wba);

    // FETCH timeout: 16 request cycles, error pulse, request re-issued
    step("to_wait0", 0, 0, 6'h00, 0, f_w0);
    for (int i = 1; i <= 15; i++) step("to_wait", 0, 0, 6'h00, 0, f_wn);
    step("to_err",   0, 1, 6'h00, 0, e_err);
    step("to_refetch", 0, 1, 6'h00, 0, f_rdy);

    // MEM timeout on lw
    step("mto_decode", 0, 0, 6'h23, 0, dec);
    step("mto_exec",   0, 0, 6'h00, 0, exi);
    for (int i = 0; i < 16; i++) step("mto_wait", 0, 0, 6'h00, 0, mlw);
    step("mto_err",    0, 0, 6'h00, 0, e_err);
    step("mto_fetch",  0, 0, 6'h00, 0, f_w0);

    // reset in the middle of a sw memory access
    step("rs_fetch",  0, 1, 6'h00, 0, f_rn);
    step("rs_decode", 0, 0, 6'h2b, 0, dec);
    step("rs_exec",   0, 0, 6'h00, 0, exi);
    step("rs_mem",    0, 0, 6'h00, 0, msw);
    step("rs_assert", 1, 0, 6'h00, 0, zro);
    step("rs_hold",   1, 1, 6'h00, 0, zro);
`ifdef CTRL_PERF_EN
    chk_cnt("cyc_reset", cyc_cnt, 32'd0);
    chk_cnt("ins_reset", ins_cnt, 32'd0);
`endif
    step("rs_release", 0, 0, 6'h00, 0, f_w0);
    step("rs_fetch2",  0, 1, 6'h00, 0, f_rn);
    step("rs_decode2", 0, 0, 6'h00, 0, dec);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
